// File: rtl/iic_reg_access_ctrl.sv
// iic_reg_access_ctrl
// Turns one register read or write request into the IIC engine's token
// stream. Device address is 7 bits, register address is 8 bits and the
// payload is 1 to 4 bytes. The block checks each ACK, gathers read data
// and returns one response with a status code.
//
// Ports
//   clk, arst        clock; asynchronous active-high reset
//   cmd_*            request: valid/ready handshake, rw, dev, reg, len (bytes-1), wdata
//   resp_*           response: valid/ready handshake, rdata, err
//                    err: 00 ok, 01 addr NACK, 10 reg/data NACK, 11 timeout
//   busy             high from accept until the response is taken
//   tok_data/tok_wr  10-bit token to the transmit FIFO, 1-cycle write strobe
//   tok_full         transmit FIFO full
//   rx_data/rx_wr    9-bit receive word from the engine: [8:1] byte, [0] ACK (0=ACK)
module iic_reg_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [6:0]  cmd_dev,
    input  logic [7:0]  cmd_reg,
    input  logic [1:0]  cmd_len,
    input  logic [31:0] cmd_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        busy,
    output logic [9:0]  tok_data,
    output logic        tok_wr,
    input  logic        tok_full,
    input  logic [8:0]  rx_data,
    input  logic        rx_wr
);

    localparam int unsigned TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TW-1:0] TO_LAST = TO_LAST_I[TW-1:0];

    localparam logic [9:0] TOK_START   = 10'b1_0_0000_0000;
    localparam logic [9:0] TOK_STOP    = 10'b1_1_0000_0000;
    localparam logic [9:0] TOK_RD_ACK  = 10'b0_1111_1111_0;
    localparam logic [9:0] TOK_RD_NACK = 10'b0_1111_1111_1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, W_ADDR, REG, W_REG, WDATA, W_WDATA,
        RSTART, ADDR_R, W_ADDR_R, RDATA, W_RDATA, STOP, RESP
    } state_t;

    state_t        state_q, state_d;
    logic          rw_q, rw_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d;
    logic [1:0]    len_q, len_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]    resp_err_q, resp_err_d;
    logic [9:0]    tok_data_q, tok_data_d;
    logic          tok_wr_q, tok_wr_d;
    logic          is_wait;
    logic          nack;

    assign nack = rx_data[0];

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        dev_d        = dev_q;
        reg_d        = reg_q;
        len_d        = len_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        tcnt_d       = tcnt_q;
        cmd_ready_d  = cmd_ready_q;
        busy_d       = busy_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        tok_data_d   = tok_data_q;
        tok_wr_d     = 1'b0;
        is_wait      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rw_d         = cmd_rw;
                    dev_d        = cmd_dev;
                    reg_d        = cmd_reg;
                    len_d        = cmd_len;
                    wdata_d      = cmd_wdata;
                    idx_d        = 2'd0;
                    tcnt_d       = '0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 2'b00;
                    cmd_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = START;
                end
            end
            START, RSTART: begin
                if (!tok_full) begin
                    tok_wr_d   = 1'b1;
                    tok_data_d = TOK_START;
                    state_d    = (state_q == START) ? ADDR_W : ADDR_R;
                end
            end
            ADDR_W: begin
                if (!tok_full) begin
                    tok_wr_d   = 1'b1;
                    tok_data_d = {1'b0, dev_q, 1'b0, 1'b1};
                    state_d    = W_ADDR;
                end
            end
            ADDR_R: begin
                if (!tok_full) begin
                    tok_wr_d   = 1'b1;
                    tok_data_d = {1'b0, dev_q, 1'b1, 1'b1};
                    state_d    = W_ADDR_R;
                end
            end
            REG: begin
                if (!tok_full) begin
                    tok_wr_d   = 1'b1;
                    tok_data_d = {1'b0, reg_q, 1'b1};
                    state_d    = W_REG;
                end
            end
            WDATA: begin
                if (!tok_full) begin
                    tok_wr_d   = 1'b1;
                    tok_data_d = {1'b0, wdata_q[{idx_q, 3'b000} +: 8], 1'b1};
                    state_d    = W_WDATA;
                end
            end
            RDATA: begin
                // Last byte gets a NACK so the slave releases SDA before STOP.
                if (!tok_full) begin
                    tok_wr_d   = 1'b1;
                    tok_data_d = (idx_q == len_q) ? TOK_RD_NACK : TOK_RD_ACK;
                    state_d    = W_RDATA;
                end
            end
            W_ADDR, W_ADDR_R: begin
                is_wait = 1'b1;
                if (rx_wr) begin
                    if (nack) begin
                        resp_err_d = 2'b01;
                        state_d    = STOP;
                    end else begin
                        state_d = (state_q == W_ADDR) ? REG : RDATA;
                    end
                end
            end
            W_REG: begin
                is_wait = 1'b1;
                if (rx_wr) begin
                    if (nack) begin
                        resp_err_d = 2'b10;
                        state_d    = STOP;
                    end else begin
                        state_d = rw_q ? RSTART : WDATA;
                    end
                end
            end
            W_WDATA: begin
                is_wait = 1'b1;
                if (rx_wr) begin
                    if (nack) begin
                        resp_err_d = 2'b10;
                        state_d    = STOP;
                    end else if (idx_q == len_q) begin
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = WDATA;
                    end
                end
            end
            W_RDATA: begin
                // ACK bit here was driven by us, so it carries no status.
                is_wait = 1'b1;
                if (rx_wr) begin
                    resp_rdata_d[{idx_q, 3'b000} +: 8] = rx_data[8:1];
                    if (idx_q == len_q) begin
                        state_d = STOP;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = RDATA;
                    end
                end
            end
            STOP: begin
                // Respond as soon as STOP is queued; the bus finishes it later.
                if (!tok_full) begin
                    tok_wr_d     = 1'b1;
                    tok_data_d   = TOK_STOP;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Wait-state timeout; a receive word in the expiry cycle takes priority.
        if (is_wait) begin
            if (rx_wr) begin
                tcnt_d = '0;
            end else if (TIMEOUT_CYCLES != 0 && tcnt_q == TO_LAST) begin
                // Engine presumed stalled: no STOP is queued.
                resp_err_d   = 2'b11;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= IDLE;
            rw_q         <= 1'b0;
            dev_q        <= 7'd0;
            reg_q        <= 8'd0;
            len_q        <= 2'd0;
            wdata_q      <= 32'd0;
            idx_q        <= 2'd0;
            tcnt_q       <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 2'b00;
            tok_data_q   <= 10'd0;
            tok_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            dev_q        <= dev_d;
            reg_q        <= reg_d;
            len_q        <= len_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            tcnt_q       <= tcnt_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            tok_data_q   <= tok_data_d;
            tok_wr_q     <= tok_wr_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign tok_data   = tok_data_q;
    assign tok_wr     = tok_wr_q;

endmodule

// File: tb/tb_iic_reg_access_ctrl.sv
// Directed bench for iic_reg_access_ctrl. A monitor records every token
// written; a responder answers each 9-bit token with the next planned
// receive word (no answer once the plan is empty).
module tb_iic_reg_access_ctrl;

    logic        clk = 1'b0;
    logic        arst;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg;
    logic [1:0]  cmd_len;
    logic [31:0] cmd_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        busy;
    logic [9:0]  tok_data;
    logic        tok_wr, tok_full;
    logic [8:0]  rx_data;
    logic        rx_wr;

    int errs   = 0;
    int checks = 0;
    logic [9:0] tokq[$];
    logic [8:0] plan[$];

    iic_reg_access_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .tok_data(tok_data), .tok_wr(tok_wr), .tok_full(tok_full),
        .rx_data(rx_data), .rx_wr(rx_wr)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (tok_wr) tokq.push_back(tok_data);
        end
    end

    initial begin
        rx_wr   = 1'b0;
        rx_data = 9'd0;
        forever begin
            @(negedge clk);
            if (tok_wr && !tok_data[9] && plan.size() > 0) begin
                rx_data = plan.pop_front();
                rx_wr   = 1'b1;
                @(negedge clk);
                rx_wr   = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [1:0] len, input logic [31:0] wd);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_reg = rg;
        cmd_len = len; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (resp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic finish_resp;
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        arst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = '0; cmd_reg = '0;
        cmd_len = '0; cmd_wdata = '0; resp_ready = 1'b0; tok_full = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        checks++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'd0) begin errs++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        checks++; if (resp_err !== 2'b00) begin errs++; $display("FAIL rst_err: got %b want 00", resp_err); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (tok_wr !== 1'b0) begin errs++; $display("FAIL rst_tok_wr: got %b want 0", tok_wr); end
        checks++; if (tok_data !== 10'd0) begin errs++; $display("FAIL rst_tok_data: got %h want 0", tok_data); end
    endtask

    task automatic test_write;
        // dev 0x50 -> address byte 0xA0 -> token 0x141
        logic [9:0] exp[$] = '{10'h200, 10'h141, 10'h021, 10'h14B, 10'h300};
        bit ok;
        tokq.delete(); plan = '{9'h000, 9'h000, 9'h000};
        send_cmd(1'b0, 7'h50, 8'h10, 2'd0, 32'h0000_00A5);
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL wr_busy: got %b want 1", busy); end
        checks++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL wr_cmd_ready: got %b want 0", cmd_ready); end
        wait_resp(ok);
        checks++; if (!ok) begin errs++; $display("FAIL wr_resp: got no response want resp_valid"); end
        checks++; if (resp_err !== 2'b00) begin errs++; $display("FAIL wr_err: got %b want 00", resp_err); end
        checks++; if (resp_rdata !== 32'd0) begin errs++; $display("FAIL wr_rdata: got %h want 0", resp_rdata); end
        finish_resp();
        checks++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL wr_resp_drop: got %b want 0", resp_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL wr_ready_back: got %b want 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL wr_busy_drop: got %b want 0", busy); end
        checks++; if (tokq.size() != exp.size()) begin errs++; $display("FAIL wr_tok_count: got %0d want %0d", tokq.size(), exp.size()); end
        else foreach (exp[i]) begin
            checks++; if (tokq[i] !== exp[i]) begin errs++; $display("FAIL wr_tok[%0d]: got %h want %h", i, tokq[i], exp[i]); end
        end
    endtask

    task automatic test_read;
        // ADDR_R byte {0x50,1}=0xA1 -> token 0x143; last data word carries ACK bit 1 (ignored)
        logic [9:0] exp[$] = '{10'h200, 10'h141, 10'h005, 10'h200, 10'h143, 10'h1FE, 10'h1FF, 10'h300};
        bit ok;
        tokq.delete(); plan = '{9'h000, 9'h000, 9'h000, 9'h078, 9'h0FD};
        send_cmd(1'b1, 7'h50, 8'h02, 2'd1, 32'hFFFF_FFFF);
        wait_resp(ok);
        checks++; if (!ok) begin errs++; $display("FAIL rd_resp: got no response want resp_valid"); end
        checks++; if (resp_rdata !== 32'h0000_7E3C) begin errs++; $display("FAIL rd_rdata: got %h want 00007e3c", resp_rdata); end
        checks++; if (resp_err !== 2'b00) begin errs++; $display("FAIL rd_err: got %b want 00", resp_err); end
        finish_resp();
        checks++; if (tokq.size() != exp.size()) begin errs++; $display("FAIL rd_tok_count: got %0d want %0d", tokq.size(), exp.size()); end
        else foreach (exp[i]) begin
            checks++; if (tokq[i] !== exp[i]) begin errs++; $display("FAIL rd_tok[%0d]: got %h want %h", i, tokq[i], exp[i]); end
        end
    endtask

    task automatic test_addr_nack;
        // dev 0x23 -> byte 0x46 -> token 0x08D
        logic [9:0] exp[$] = '{10'h200, 10'h08D, 10'h300};
        bit ok;
        tokq.delete(); plan = '{9'h001};
        send_cmd(1'b0, 7'h23, 8'h44, 2'd2, 32'h00CC_BBAA);
        wait_resp(ok);
        checks++; if (!ok) begin errs++; $display("FAIL an_resp: got no response want resp_valid"); end
        checks++; if (resp_err !== 2'b01) begin errs++; $display("FAIL an_err: got %b want 01", resp_err); end
        finish_resp();
        checks++; if (tokq.size() != exp.size()) begin errs++; $display("FAIL an_tok_count: got %0d want %0d", tokq.size(), exp.size()); end
        else foreach (exp[i]) begin
            checks++; if (tokq[i] !== exp[i]) begin errs++; $display("FAIL an_tok[%0d]: got %h want %h", i, tokq[i], exp[i]); end
        end
    endtask

    task automatic test_data_nack;
        logic [9:0] exp[$] = '{10'h200, 10'h141, 10'h041, 10'h023, 10'h045, 10'h300};
        bit ok;
        tokq.delete(); plan = '{9'h000, 9'h000, 9'h000, 9'h001};
        send_cmd(1'b0, 7'h50, 8'h20, 2'd3, 32'h4433_2211);
        wait_resp(ok);
        checks++; if (!ok) begin errs++; $display("FAIL dn_resp: got no response want resp_valid"); end
        checks++; if (resp_err !== 2'b10) begin errs++; $display("FAIL dn_err: got %b want 10", resp_err); end
        finish_resp();
        checks++; if (tokq.size() != exp.size()) begin errs++; $display("FAIL dn_tok_count: got %0d want %0d", tokq.size(), exp.size()); end
        else foreach (exp[i]) begin
            checks++; if (tokq[i] !== exp[i]) begin errs++; $display("FAIL dn_tok[%0d]: got %h want %h", i, tokq[i], exp[i]); end
        end
    endtask

    task automatic test_full_timeout;
        bit seen;
        int stray, cyc;
        tokq.delete(); plan.delete();
        send_cmd(1'b0, 7'h50, 8'h10, 2'd0, 32'h0000_00A5);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tok_wr && tok_data == 10'h200) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errs++; $display("FAIL ft_start: got no START token want 200"); end
        tok_full = 1'b1;
        stray = 0;
        repeat (50) begin
            @(negedge clk);
            if (tok_wr) stray++;
        end
        checks++; if (stray != 0) begin errs++; $display("FAIL ft_hold: got %0d writes while full want 0", stray); end
        tok_full = 1'b0;
        @(negedge clk);
        checks++; if (tok_wr !== 1'b1 || tok_data !== 10'h141) begin errs++; $display("FAIL ft_addr: got wr=%b data=%h want wr=1 data=141", tok_wr, tok_data); end
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) break;
        end
        checks++; if (cyc != 100) begin errs++; $display("FAIL ft_timeout_cycles: got %0d want 100", cyc); end
        checks++; if (resp_err !== 2'b11) begin errs++; $display("FAIL ft_err: got %b want 11", resp_err); end
        finish_resp();
        checks++; if (tokq.size() != 2) begin errs++; $display("FAIL ft_no_stop: got %0d tokens want 2", tokq.size()); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] exp[$] = '{10'h200, 10'h141, 10'h021, 10'h14B, 10'h300};
        bit seen, ok;
        tokq.delete(); plan = '{9'h000, 9'h000, 9'h000};
        send_cmd(1'b1, 7'h50, 8'h02, 2'd1, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tok_wr && tok_data == 10'h1FE) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errs++; $display("FAIL rm_rdata_tok: got none want 1fe"); end
        repeat (3) @(negedge clk);
        arst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || resp_valid !== 1'b0 || tok_wr !== 1'b0 || tok_data !== 10'd0)
            begin errs++; $display("FAIL rm_reset_outs: got busy=%b rdy=%b rv=%b twr=%b tdata=%h want 0 1 0 0 000", busy, cmd_ready, resp_valid, tok_wr, tok_data); end
        @(negedge clk);
        arst = 1'b0;
        tokq.delete(); plan = '{9'h000, 9'h000, 9'h000};
        send_cmd(1'b0, 7'h50, 8'h10, 2'd0, 32'h0000_00A5);
        wait_resp(ok);
        checks++; if (!ok) begin errs++; $display("FAIL rm_resp: got no response want resp_valid"); end
        checks++; if (resp_err !== 2'b00) begin errs++; $display("FAIL rm_err: got %b want 00", resp_err); end
        finish_resp();
        checks++; if (tokq.size() != exp.size()) begin errs++; $display("FAIL rm_tok_count: got %0d want %0d", tokq.size(), exp.size()); end
        else foreach (exp[i]) begin
            checks++; if (tokq[i] !== exp[i]) begin errs++; $display("FAIL rm_tok[%0d]: got %h want %h", i, tokq[i], exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_full_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
